// File: rtl/router_fsm_pkg.sv
// Shared state encoding and address width for the router input-stage control FSM.
package router_fsm_pkg;

  localparam int ADDR_W = 2;

  localparam logic [2:0] ST_DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] ST_LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] ST_LOAD_DATA          = 3'd2;
  localparam logic [2:0] ST_FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] ST_LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] ST_LOAD_PARITY        = 3'd5;
  localparam logic [2:0] ST_CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] ST_WAIT_TILL_EMPTY    = 3'd7;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = ST_DECODE_ADDRESS,
    LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
    LOAD_DATA          = ST_LOAD_DATA,
    FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
    LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
    LOAD_PARITY        = ST_LOAD_PARITY,
    CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY
  } state_t;

endpackage

// File: rtl/router_fsm_if.sv
// Control bundle between the router FSM and the source/router_reg/FIFO side.
interface router_fsm_if #(parameter int NUM_PORTS = 3);

  logic                 pkt_valid;
  logic [1:0]           data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 write_enb_reg;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 busy;

  // Environment side: source, FIFOs and router_reg status.
  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, busy
  );

  // FSM side.
  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_pkt_valid,
    output write_enb_reg, detect_add, lfd_state, ld_state, laf_state,
           full_state, rst_int_reg, busy
  );

endinterface

// File: rtl/router_fsm.sv
// Router input-stage control FSM: header decode, FIFO wait, payload/parity sequencing.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header with a valid address
// LOAD_FIRST_DATA    | header byte written into router_reg
// LOAD_DATA          | payload bytes streaming into the FIFO
// FIFO_FULL_STATE    | destination FIFO full, source held off
// LOAD_AFTER_FULL    | write the byte held during the full condition
// LOAD_PARITY        | parity byte written
// CHECK_PARITY_ERROR | router_reg compares parity, internal regs cleared
// WAIT_TILL_EMPTY    | destination FIFO still draining a previous packet
module router_fsm
  import router_fsm_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input logic           clock,
  input logic           resetn,
  router_fsm_if.slave   bus
);

  localparam logic [2:0] NUM_PORTS_W = 3'(NUM_PORTS);

  state_t            state_q;
  state_t            state_nxt;
  logic [ADDR_W-1:0] dest_q;
  logic [3:0]        empty_ext;
  logic [3:0]        soft_ext;
  logic              addr_ok;

  logic write_enb_q;
  logic detect_add_q;
  logic lfd_state_q;
  logic ld_state_q;
  logic laf_state_q;
  logic full_state_q;
  logic rst_int_reg_q;
  logic busy_q;

  // Widen per-port flags to the full address space so any 2-bit index is in range.
  always_comb begin
    empty_ext = '0;
    soft_ext  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      empty_ext[i] = bus.fifo_empty[i];
      soft_ext[i]  = bus.soft_reset[i];
    end
  end

  assign addr_ok = ({1'b0, bus.data_in} < NUM_PORTS_W);

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && addr_ok) begin
          state_nxt = empty_ext[bus.data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty_ext[dest_q]) state_nxt = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
        else                        state_nxt = LOAD_DATA;
      end
      LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_nxt = DECODE_ADDRESS;
    endcase
    // A timeout on the selected FIFO abandons the packet from any active state.
    if (state_q != DECODE_ADDRESS && soft_ext[dest_q]) state_nxt = DECODE_ADDRESS;
  end

  // Outputs are decoded from the next state so they appear registered alongside it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= DECODE_ADDRESS;
      dest_q        <= '0;
      write_enb_q   <= 1'b0;
      detect_add_q  <= 1'b1;
      lfd_state_q   <= 1'b0;
      ld_state_q    <= 1'b0;
      laf_state_q   <= 1'b0;
      full_state_q  <= 1'b0;
      rst_int_reg_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q <= state_nxt;
      if (state_q == DECODE_ADDRESS && bus.pkt_valid && addr_ok) dest_q <= bus.data_in;
      write_enb_q   <= (state_nxt == LOAD_DATA) || (state_nxt == LOAD_AFTER_FULL) ||
                       (state_nxt == LOAD_PARITY);
      detect_add_q  <= (state_nxt == DECODE_ADDRESS);
      lfd_state_q   <= (state_nxt == LOAD_FIRST_DATA);
      ld_state_q    <= (state_nxt == LOAD_DATA);
      laf_state_q   <= (state_nxt == LOAD_AFTER_FULL);
      full_state_q  <= (state_nxt == FIFO_FULL_STATE);
      rst_int_reg_q <= (state_nxt == CHECK_PARITY_ERROR);
      busy_q        <= (state_nxt != DECODE_ADDRESS) && (state_nxt != LOAD_DATA);
    end
  end

  assign bus.write_enb_reg = write_enb_q;
  assign bus.detect_add    = detect_add_q;
  assign bus.lfd_state     = lfd_state_q;
  assign bus.ld_state      = ld_state_q;
  assign bus.laf_state     = laf_state_q;
  assign bus.full_state    = full_state_q;
  assign bus.rst_int_reg   = rst_int_reg_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm with a phase-level reference model checked every cycle.
module tb_router_fsm;

  localparam int NP = 3;

  // Model phases (bench-local numbering).
  localparam int P_IDLE = 0, P_WAIT = 1, P_HDR = 2, P_PAY = 3,
                 P_FULL = 4, P_AFTER = 5, P_PAR = 6, P_CHK = 7;

  // Output vector: {we, detect, lfd, ld, laf, full, rst_int, busy}
  localparam logic [7:0] V_DEC  = 8'b0100_0000;
  localparam logic [7:0] V_LFD  = 8'b0010_0001;
  localparam logic [7:0] V_LD   = 8'b1001_0000;
  localparam logic [7:0] V_FULL = 8'b0000_0101;
  localparam logic [7:0] V_LAF  = 8'b1000_1001;
  localparam logic [7:0] V_LP   = 8'b1000_0001;
  localparam logic [7:0] V_CPE  = 8'b0000_0011;
  localparam logic [7:0] V_WAIT = 8'b0000_0001;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   tests  = 0;
  int   fails  = 0;
  bit   cmp_en = 1'b0;
  int   mp     = P_IDLE;
  logic [1:0] md = 2'b00;

  router_fsm_if #(.NUM_PORTS(NP)) bus ();

  router_fsm #(.NUM_PORTS(NP)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] dut_vec;
  assign dut_vec = {bus.write_enb_reg, bus.detect_add, bus.lfd_state, bus.ld_state,
                    bus.laf_state, bus.full_state, bus.rst_int_reg, bus.busy};

  function automatic logic [7:0] model_out(int p);
    logic we, bz;
    we = (p == P_PAY) || (p == P_AFTER) || (p == P_PAR);
    bz = !((p == P_IDLE) || (p == P_PAY));
    return {we, p == P_IDLE, p == P_HDR, p == P_PAY, p == P_AFTER, p == P_FULL,
            p == P_CHK, bz};
  endfunction

  function automatic int model_next(int p, logic pv, logic [1:0] din, logic ff,
                                    logic [NP-1:0] fe, logic [NP-1:0] sr,
                                    logic pd, logic lpv, logic [1:0] dq);
    int a, d;
    a = int'(din);
    d = int'(dq);
    if (p != P_IDLE && d < NP && sr[d]) return P_IDLE;
    case (p)
      P_IDLE:  if (pv && a < NP) return fe[a] ? P_HDR : P_WAIT; else return P_IDLE;
      P_WAIT:  return (d < NP && fe[d]) ? P_HDR : P_WAIT;
      P_HDR:   return P_PAY;
      P_PAY:   return ff ? P_FULL : (!pv ? P_PAR : P_PAY);
      P_FULL:  return ff ? P_FULL : P_AFTER;
      P_AFTER: return pd ? P_IDLE : (lpv ? P_PAR : P_PAY);
      P_PAR:   return P_CHK;
      default: return ff ? P_FULL : P_IDLE;
    endcase
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mp <= P_IDLE;
      md <= 2'b00;
    end else begin
      mp <= model_next(mp, bus.pkt_valid, bus.data_in, bus.fifo_full, bus.fifo_empty,
                       bus.soft_reset, bus.parity_done, bus.low_pkt_valid, md);
      if (mp == P_IDLE && bus.pkt_valid && int'(bus.data_in) < NP) md <= bus.data_in;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (cmp_en) check("model_cycle", dut_vec, model_out(mp));
  end

  // Literal expectation against both the DUT and the model.
  task automatic expect_now(input string name, input logic [7:0] lit);
    check(name, dut_vec, lit);
    check({name, "_model"}, model_out(mp), lit);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'b00;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty    = '1;
    bus.soft_reset    = '0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;

    step();
    cmp_en = 1'b1;
    step();
    resetn = 1'b1;
    expect_now("reset_state", V_DEC);

    // Clean packet to port 1
    bus.data_in = 2'b01; bus.fifo_empty = 3'b010; bus.pkt_valid = 1'b1;
    step(); expect_now("clean_lfd", V_LFD);
    step(); expect_now("clean_ld1", V_LD);
    step(); expect_now("clean_ld2", V_LD);
    step(); expect_now("clean_ld3", V_LD);
    bus.pkt_valid = 1'b0;
    step(); expect_now("clean_lp", V_LP);
    step(); expect_now("clean_cpe", V_CPE);
    step(); expect_now("clean_dec", V_DEC);

    // Wait for port 2 to drain
    bus.data_in = 2'b10; bus.fifo_empty = 3'b011; bus.pkt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); expect_now("wait_busy", V_WAIT);
    end
    bus.fifo_empty = 3'b111;
    step(); expect_now("wait_lfd", V_LFD);
    step(); expect_now("wait_ld", V_LD);

    // Full handling, resume variant
    bus.fifo_full = 1'b1;
    step(); expect_now("full_1", V_FULL);
    step(); expect_now("full_2", V_FULL);
    bus.fifo_full = 1'b0;
    step(); expect_now("laf_a", V_LAF);
    step(); expect_now("laf_resume_ld", V_LD);
    // low_pkt_valid variant
    bus.fifo_full = 1'b1;
    step(); expect_now("full_3", V_FULL);
    bus.fifo_full = 1'b0;
    step(); expect_now("laf_b", V_LAF);
    bus.low_pkt_valid = 1'b1;
    step(); expect_now("laf_low_lp", V_LP);
    bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
    step(); expect_now("laf_low_cpe", V_CPE);
    step(); expect_now("laf_low_dec", V_DEC);
    // parity_done variant, also with low_pkt_valid high to show priority
    bus.data_in = 2'b10; bus.pkt_valid = 1'b1;
    step(); expect_now("pd_lfd", V_LFD);
    step(); expect_now("pd_ld", V_LD);
    bus.fifo_full = 1'b1;
    step(); expect_now("pd_full", V_FULL);
    bus.fifo_full = 1'b0;
    step(); expect_now("pd_laf", V_LAF);
    bus.parity_done = 1'b1; bus.low_pkt_valid = 1'b1;
    step(); expect_now("pd_dec", V_DEC);
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0; bus.pkt_valid = 1'b0;
    step(); expect_now("pd_idle", V_DEC);

    // CHECK_PARITY_ERROR with FIFO full goes back to full handling
    bus.data_in = 2'b00; bus.pkt_valid = 1'b1;
    step(); expect_now("cpe_lfd", V_LFD);
    step(); expect_now("cpe_ld", V_LD);
    bus.pkt_valid = 1'b0;
    step(); expect_now("cpe_lp", V_LP);
    step(); expect_now("cpe_cpe", V_CPE);
    bus.fifo_full = 1'b1;
    step(); expect_now("cpe_full", V_FULL);
    bus.fifo_full = 1'b0;
    step(); expect_now("cpe_laf", V_LAF);
    bus.parity_done = 1'b1;
    step(); expect_now("cpe_dec", V_DEC);
    bus.parity_done = 1'b0;

    // Soft reset with dest 01 during FIFO_FULL_STATE
    bus.data_in = 2'b01; bus.pkt_valid = 1'b1;
    step(); expect_now("sr_lfd", V_LFD);
    step(); expect_now("sr_ld", V_LD);
    bus.fifo_full = 1'b1;
    step(); expect_now("sr_full", V_FULL);
    bus.soft_reset = 3'b100;
    step(); expect_now("sr_other_port", V_FULL);
    bus.soft_reset = 3'b010;
    step(); expect_now("sr_own_port", V_DEC);
    bus.soft_reset = 3'b000; bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
    step(); expect_now("sr_idle", V_DEC);

    // Invalid address holds in DECODE_ADDRESS
    bus.data_in = 2'b11; bus.pkt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_now("invalid_addr", V_DEC);
    end
    bus.pkt_valid = 1'b0;
    step();

    // Asynchronous reset in the middle of LOAD_DATA
    bus.data_in = 2'b00; bus.fifo_empty = 3'b001; bus.pkt_valid = 1'b1;
    step(); expect_now("ar_lfd", V_LFD);
    step(); expect_now("ar_ld", V_LD);
    #2;
    resetn = 1'b0;
    #1;
    expect_now("async_reset", V_DEC);
    bus.pkt_valid = 1'b0;
    step();
    resetn = 1'b1;
    step(); expect_now("post_reset", V_DEC);
    step();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
